alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//  Parametrised successor to the combinational CPU ALU. Keeps the 5-bit opcode set and zero flag,
//  adds a valid/ready handshake, signed-overflow and divide-by-zero flags, and iterative
//  multiply/divide (one bit per cycle). Sits in EX; the pipeline stalls on in_ready/out_valid.
// PARAMETERS
//  WIDTH   32   operand/result width; power of two, >=8
//  SHW     $clog2(WIDTH)   derived, not overridden; index width of the iteration counter
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-high reset
//  in_valid     in   1      op/a/b valid
//  in_ready     out  1      block can accept; transfer when in_valid & in_ready
//  op           in   5      opcode (table below)
//  a            in   WIDTH  operand A
//  b            in   WIDTH  operand B (shift amount for shifts)
//  out_valid    out  1      result valid; held until out_ready
//  out_ready    in   1      consumer accepts result
//  result       out  WIDTH  main result / product low / quotient
//  result_hi    out  WIDTH  product high / remainder; 0 for other ops
//  zero         out  1      result == 0
//  overflow     out  1      signed overflow, ADD/SUB only
//  div_by_zero  out  1      DIV/DIVU with b == 0
// BEHAVIOUR
//  Opcodes:
//   00000 ADD    00001 ADDU   00010 SUB    00011 SUBU   00100 AND    00101 OR
//   00110 XOR    00111 NOR    01000 SLT    01001 SLTU   01010 SLL    01011 SRA
//   01100 SRL    01101 EQ     01110 NE     10000 MULU   10001 MUL    10010 DIVU   10011 DIV
//   Other codes: result 0, flags 0, single-cycle.
//  - SLT/SLTU/EQ/NE: result = {WIDTH-1 zeros, bit}.
//  - Shifts: the full b is the amount. If b >= WIDTH: SLL/SRL give 0, SRA gives WIDTH copies of a[MSB].
//  - Add/sub wrap modulo 2^WIDTH. overflow is set for ADD/SUB on signed overflow; it is 0 for ADDU/SUBU.
//  - MUL/MULU: full 2*WIDTH product, split as {result_hi, result}.
//  - DIV truncates toward zero; the remainder takes the sign of a.
//  - DIV/DIVU with b == 0: result all-ones, result_hi = a, div_by_zero = 1.
//  - DIV with MIN/-1: result = MIN, result_hi = 0, no flag.
//  - Signed MUL/DIV run on magnitudes; the sign is fixed in the final cycle.
//  FSM: IDLE, EXEC, DONE.
//   - IDLE: in_ready=1. On accept: single-cycle op -> DONE; MUL*/DIV* -> EXEC with counter = 0.
//   - EXEC: one shift-add or shift-subtract step per cycle. After WIDTH steps -> DONE.
//   - DONE: out_valid=1; result and all flags are registered and held stable.
//     If out_ready and in_valid are both high, the new op is accepted in the same cycle
//     (in_ready = out_ready in DONE) and the FSM goes back to DONE or EXEC.
//     If only out_ready is high -> IDLE.
//  - in_ready=0 in EXEC, and in DONE when out_ready=0.
//  - Latency from the accept edge to out_valid: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL/DIV.
//  - Operands are captured at accept. Input changes after accept have no effect.
//  - rst (any time, including mid-EXEC): state=IDLE, counter=0, out_valid=0, result=0,
//    result_hi=0, zero=0, overflow=0, div_by_zero=0, in_ready=0 while rst is high.
//    The in-flight op is discarded with no output.
// TESTING
//  1. ADD a=7fffffff b=70000001 -> result f0000000, overflow=1, zero=0, out_valid 1 cycle after accept;
//     ADDU with the same operands -> overflow=0.
//  2. SRA a=f0001231 b=20 -> ffffffff; SLL with the same operands -> 0, zero=1;
//     SRL a=f1a2c371 b=9 -> 0078d161.
//  3. MUL a=-62 b=108 -> result ffffe5d8, result_hi ffffffff, out_valid exactly WIDTH+1=33 cycles
//     after accept, in_ready=0 during EXEC.
//  4. DIV a=-108 b=62 -> result ffffffff, result_hi ffffffd2;
//     DIVU a=5 b=0 -> result ffffffff, result_hi 5, div_by_zero=1;
//     DIV a=80000000 b=ffffffff -> result 80000000, result_hi 0.
//  5. Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; then raise out_ready with
//     in_valid=1 (AND 72340000 & 60000000) -> next cycle result 60000000, no idle bubble.
//  6. Assert rst at cycle 10 of a DIVU -> out_valid=0 and all outputs 0 immediately; after release,
//     SLTU a=1 b=ffffffff -> result 1.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle logic/arith/shift ops plus
// iterative shift-add multiply and restoring divide (one bit per cycle).
module alu_multicycle #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned M   = WIDTH - 1;
    localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

    localparam logic [4:0] OpAdd  = 5'b00000, OpAddu = 5'b00001, OpSub = 5'b00010;
    localparam logic [4:0] OpSubu = 5'b00011, OpAnd  = 5'b00100, OpOr  = 5'b00101;
    localparam logic [4:0] OpXor  = 5'b00110, OpNor  = 5'b00111, OpSlt = 5'b01000;
    localparam logic [4:0] OpSltu = 5'b01001, OpSll  = 5'b01010, OpSra = 5'b01011;
    localparam logic [4:0] OpSrl  = 5'b01100, OpEq   = 5'b01101, OpNe  = 5'b01110;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic             div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dbz_q, dbz_d;
    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic             zero_q, zero_d, overflow_q, overflow_d, div_by_zero_q, div_by_zero_d;

    logic             in_fire, is_mc;
    logic [WIDTH-1:0] sum, diff, alu_res, mag_a, mag_b;
    logic             alu_ovf, alu_known, big_shift;
    logic [SHW-1:0]   shamt;

    assign in_ready = !rst && (state_q == StIdle || (state_q == StDone && out_ready));
    assign in_fire  = in_valid && in_ready;
    assign is_mc    = (op[4:2] == 3'b100);
    // op[0] marks the signed variants of MUL/DIV
    assign mag_a    = (op[0] && a[M]) ? ('0 - a) : a;
    assign mag_b    = (op[0] && b[M]) ? ('0 - b) : b;

    always_comb begin
        sum       = a + b;
        diff      = a - b;
        big_shift = |b[WIDTH-1:SHW];
        shamt     = b[SHW-1:0];
        alu_res   = '0;
        alu_ovf   = 1'b0;
        alu_known = 1'b1;
        case (op)
            OpAdd: begin
                alu_res = sum;
                alu_ovf = (a[M] == b[M]) && (sum[M] != a[M]);
            end
            OpAddu: alu_res = sum;
            OpSub: begin
                alu_res = diff;
                alu_ovf = (a[M] != b[M]) && (diff[M] != a[M]);
            end
            OpSubu: alu_res = diff;
            OpAnd:  alu_res = a & b;
            OpOr:   alu_res = a | b;
            OpXor:  alu_res = a ^ b;
            OpNor:  alu_res = ~(a | b);
            OpSlt:  alu_res[0] = $signed(a) < $signed(b);
            OpSltu: alu_res[0] = a < b;
            OpSll:  alu_res = big_shift ? '0 : (a << shamt);
            OpSra:  alu_res = big_shift ? {WIDTH{a[M]}} : WIDTH'($signed(a) >>> shamt);
            OpSrl:  alu_res = big_shift ? '0 : (a >> shamt);
            OpEq:   alu_res[0] = (a == b);
            OpNe:   alu_res[0] = (a != b);
            default: alu_known = 1'b0;
        endcase
    end

    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [WIDTH-1:0]   addend, step_hi, step_lo, quo, rem, fin_res, fin_hi;
    logic [2*WIDTH-1:0] prod, prod_s;

    always_comb begin
        addend   = lo_q[0] ? m_q : {WIDTH{1'b0}};
        mul_sum  = {1'b0, hi_q} + {1'b0, addend};
        div_sh   = {hi_q, lo_q[M]};
        div_diff = div_sh - {1'b0, m_q};
        if (!div_q) begin
            {step_hi, step_lo} = {mul_sum, lo_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            step_hi = div_diff[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = div_sh[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b0};
        end
        // Sign correction is folded into the last iteration
        prod   = {step_hi, step_lo};
        prod_s = neg_q ? ('0 - prod) : prod;
        quo    = neg_q ? ('0 - step_lo) : step_lo;
        rem    = rneg_q ? ('0 - step_hi) : step_hi;
        if (div_q) begin
            fin_res = dbz_q ? '1 : quo;
            fin_hi  = rem;
        end else begin
            fin_res = prod_s[WIDTH-1:0];
            fin_hi  = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        m_d           = m_q;
        div_d         = div_q;
        neg_d         = neg_q;
        rneg_d        = rneg_q;
        dbz_d         = dbz_q;
        result_d      = result_q;
        result_hi_d   = result_hi_q;
        zero_d        = zero_q;
        overflow_d    = overflow_q;
        div_by_zero_d = div_by_zero_q;
        case (state_q)
            StExec: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d       = StDone;
                    cnt_d         = '0;
                    result_d      = fin_res;
                    result_hi_d   = fin_hi;
                    zero_d        = (fin_res == '0);
                    overflow_d    = 1'b0;
                    div_by_zero_d = div_q && dbz_q;
                end
            end
            StDone: if (out_ready) state_d = StIdle;
            default: ;
        endcase
        if (in_fire) begin
            if (is_mc) begin
                state_d = StExec;
                cnt_d   = '0;
                hi_d    = '0;
                lo_d    = op[1] ? mag_a : mag_b;
                m_d     = op[1] ? mag_b : mag_a;
                div_d   = op[1];
                neg_d   = op[0] && (a[M] ^ b[M]);
                rneg_d  = op[0] && a[M];
                dbz_d   = op[1] && (b == '0);
            end else begin
                state_d       = StDone;
                result_d      = alu_res;
                result_hi_d   = '0;
                zero_d        = alu_known && (alu_res == '0);
                overflow_d    = alu_ovf;
                div_by_zero_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            m_q           <= '0;
            div_q         <= 1'b0;
            neg_q         <= 1'b0;
            rneg_q        <= 1'b0;
            dbz_q         <= 1'b0;
            result_q      <= '0;
            result_hi_q   <= '0;
            zero_q        <= 1'b0;
            overflow_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            m_q           <= m_d;
            div_q         <= div_d;
            neg_q         <= neg_d;
            rneg_q        <= rneg_d;
            dbz_q         <= dbz_d;
            result_q      <= result_d;
            result_hi_q   <= result_hi_d;
            zero_q        <= zero_d;
            overflow_q    <= overflow_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign out_valid   = (state_q == StDone);
    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign zero        = zero_q;
    assign overflow    = overflow_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: driver pushes expected responses, monitor pops and
// compares whenever the DUT presents a result.
module tb_alu_multicycle;
    localparam logic [4:0] OpAdd = 5'b00000, OpAddu = 5'b00001, OpSub = 5'b00010;
    localparam logic [4:0] OpSubu = 5'b00011, OpAnd = 5'b00100, OpXor = 5'b00110;
    localparam logic [4:0] OpNor = 5'b00111, OpSlt = 5'b01000, OpSltu = 5'b01001;
    localparam logic [4:0] OpSll = 5'b01010, OpSra = 5'b01011, OpSrl = 5'b01100;
    localparam logic [4:0] OpEq = 5'b01101, OpNe = 5'b01110, OpBad = 5'b01111;
    localparam logic [4:0] OpMulu = 5'b10000, OpMul = 5'b10001, OpDivu = 5'b10010;
    localparam logic [4:0] OpDiv = 5'b10011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result, result_hi;
    logic        zero, overflow, div_by_zero;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .result_hi(result_hi),
        .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        ov;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic issue(input string nm, input logic [4:0] o, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [31:0] r, input logic [31:0] h,
                         input logic z, input logic ov, input logic dz, input int lat,
                         input bit push);
        exp_t e;
        int   n = 0;
        op = o; a = aa; b = bb; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s accept: in_ready stuck at 0, expected 1", nm);
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            e.nm = nm; e.res = r; e.hi = h; e.z = z; e.ov = ov; e.dz = dz;
            e.lat = lat; e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        a = 32'hdead_beef;
        b = 32'h0bad_f00d;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    exp_t cur;
    bit   seen = 1'b0;

    always @(negedge clk) begin
        #3;
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_output: got out_valid=1 result=%h, expected none", result);
            end else begin
                cur = sb[0];
                if (!seen) begin
                    seen = 1'b1;
                    check({cur.nm, " latency"}, 64'(cyc - cur.acc + 1), 64'(cur.lat));
                end
                check({cur.nm, " result"}, {32'h0, result}, {32'h0, cur.res});
                check({cur.nm, " result_hi"}, {32'h0, result_hi}, {32'h0, cur.hi});
                check({cur.nm, " flags"}, {61'h0, zero, overflow, div_by_zero},
                      {61'h0, cur.z, cur.ov, cur.dz});
                if (!out_ready) check({cur.nm, " in_ready_hold"}, {63'h0, in_ready}, 64'h0);
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #1;
        check("reset out_valid", {63'h0, out_valid}, 64'h0);
        check("reset in_ready", {63'h0, in_ready}, 64'h0);
        check("reset outputs", {result, result_hi}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        issue("add_ovf", OpAdd, 32'h7fffffff, 32'h70000001, 32'hf0000000, 0, 0, 1, 0, 1, 1);
        issue("addu", OpAddu, 32'h7fffffff, 32'h70000001, 32'hf0000000, 0, 0, 0, 0, 1, 1);
        issue("sub_ovf", OpSub, 32'h80000000, 32'h00000001, 32'h7fffffff, 0, 0, 1, 0, 1, 1);
        issue("subu", OpSubu, 32'h0, 32'h1, 32'hffffffff, 0, 0, 0, 0, 1, 1);
        issue("sra_big", OpSra, 32'hf0001231, 32'h20, 32'hffffffff, 0, 0, 0, 0, 1, 1);
        issue("sll_big", OpSll, 32'hf0001231, 32'h20, 32'h0, 0, 1, 0, 0, 1, 1);
        issue("srl", OpSrl, 32'hf1a2c371, 32'h9, 32'h0078d161, 0, 0, 0, 0, 1, 1);
        issue("sra", OpSra, 32'h80000000, 32'h4, 32'hf8000000, 0, 0, 0, 0, 1, 1);
        issue("slt", OpSlt, 32'hffffffff, 32'h1, 32'h1, 0, 0, 0, 0, 1, 1);
        issue("nor", OpNor, 32'h0, 32'h0, 32'hffffffff, 0, 0, 0, 0, 1, 1);
        issue("eq", OpEq, 32'h5, 32'h5, 32'h1, 0, 0, 0, 0, 1, 1);
        issue("ne", OpNe, 32'h5, 32'h5, 32'h0, 0, 1, 0, 0, 1, 1);
        issue("undef", OpBad, 32'h1, 32'h1, 32'h0, 0, 0, 0, 0, 1, 1);

        issue("mul", OpMul, 32'hffffffc2, 32'h6c, 32'hffffe5d8, 32'hffffffff, 0, 0, 0, 33, 1);
        repeat (3) begin
            #1;
            check("mul exec in_ready", {63'h0, in_ready}, 64'h0);
            @(negedge clk);
        end
        issue("mulu", OpMulu, 32'hffffffff, 32'hffffffff, 32'h1, 32'hfffffffe, 0, 0, 0, 33, 1);
        issue("div", OpDiv, 32'hffffff94, 32'h3e, 32'hffffffff, 32'hffffffd2, 0, 0, 0, 33, 1);
        issue("divu_by0", OpDivu, 32'h5, 32'h0, 32'hffffffff, 32'h5, 0, 0, 1, 33, 1);
        issue("div_min", OpDiv, 32'h80000000, 32'hffffffff, 32'h80000000, 32'h0, 0, 0, 0, 33, 1);
        issue("divu", OpDivu, 32'h64, 32'h7, 32'he, 32'h2, 0, 0, 0, 33, 1);
        issue("div_negb", OpDiv, 32'h7, 32'hfffffffe, 32'hfffffffd, 32'h1, 0, 0, 0, 33, 1);
        drain();

        out_ready = 1'b0;
        issue("xor_hold", OpXor, 32'hf0f0f0f0, 32'hff00ff00, 32'h0ff00ff0, 0, 0, 0, 0, 1, 1);
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        issue("and_b2b", OpAnd, 32'h72340000, 32'h60000000, 32'h60000000, 0, 0, 0, 0, 1, 1);
        drain();

        issue("divu_killed", OpDivu, 32'hffffffff, 32'h3, 0, 0, 0, 0, 0, 33, 0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst out_valid", {63'h0, out_valid}, 64'h0);
        check("rst in_ready", {63'h0, in_ready}, 64'h0);
        check("rst result", {result, result_hi}, 64'h0);
        check("rst flags", {61'h0, zero, overflow, div_by_zero}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        issue("sltu", OpSltu, 32'h1, 32'hffffffff, 32'h1, 0, 0, 0, 0, 1, 1);
        drain();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
